// File: rtl/sys_ctrl_if.sv
// sys_ctrl_if: UART RX, register file, ALU and TX FIFO signals seen by the sequencer
interface sys_ctrl_if #(parameter int DATA_WIDTH = 8, parameter int ADDR_WIDTH = 4);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RF_RdData;
  logic                    RF_RdData_Valid;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_Valid;
  logic                    FIFO_FULL;
  logic [ADDR_WIDTH-1:0]   RF_Address;
  logic                    RF_WrEn;
  logic                    RF_RdEn;
  logic [DATA_WIDTH-1:0]   RF_WrData;
  logic                    ALU_EN;
  logic [3:0]              ALU_FUN;
  logic                    CLK_GATE_EN;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_Valid, FIFO_FULL,
    output RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_Valid, FIFO_FULL,
    input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_ctrl.sv
// sys_ctrl: decodes UART command frames into register-file, ALU and TX FIFO transactions
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic       CLK,
  input logic       RST,
  sys_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN_S, ALU_WAIT, TX_RD, TX_LO, TX_HI
  } state_t;
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [2*DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0]   rx;
  logic                    vld;
  assign rx  = bus.RX_P_DATA;
  assign vld = bus.RX_D_VLD;
  // frame sequencer; every output is a register and strobes default low each cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      addr_q          <= '0;
      rd_q            <= '0;
      alu_q           <= '0;
      bus.RF_Address  <= '0;
      bus.RF_WrEn     <= 1'b0;
      bus.RF_RdEn     <= 1'b0;
      bus.RF_WrData   <= '0;
      bus.ALU_EN      <= 1'b0;
      bus.ALU_FUN     <= '0;
      bus.CLK_GATE_EN <= 1'b0;
      bus.TX_P_DATA   <= '0;
      bus.TX_D_VLD    <= 1'b0;
    end else begin
      bus.RF_WrEn  <= 1'b0;
      bus.RF_RdEn  <= 1'b0;
      bus.ALU_EN   <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      case (state)
        IDLE: if (vld) begin
          case (rx)
            DATA_WIDTH'(8'hAA): state <= WR_ADDR;
            DATA_WIDTH'(8'hBB): state <= RD_ADDR;
            DATA_WIDTH'(8'hCC): state <= OP_A;
            DATA_WIDTH'(8'hDD): state <= ALU_FUN_S;
            default:            state <= IDLE;
          endcase
        end
        WR_ADDR: if (vld) begin
          addr_q <= rx[ADDR_WIDTH-1:0];
          state  <= WR_DATA;
        end
        WR_DATA: if (vld) begin
          bus.RF_WrEn    <= 1'b1;
          bus.RF_Address <= addr_q;
          bus.RF_WrData  <= rx;
          state          <= IDLE;
        end
        RD_ADDR: if (vld) begin
          bus.RF_RdEn    <= 1'b1;
          bus.RF_Address <= rx[ADDR_WIDTH-1:0];
          state          <= RD_WAIT;
        end
        RD_WAIT: if (bus.RF_RdData_Valid) begin
          rd_q  <= bus.RF_RdData;
          state <= TX_RD;
        end
        TX_RD: if (!bus.FIFO_FULL) begin
          bus.TX_D_VLD  <= 1'b1;
          bus.TX_P_DATA <= rd_q;
          state         <= IDLE;
        end
        OP_A: if (vld) begin
          bus.RF_WrEn    <= 1'b1;
          bus.RF_Address <= '0;
          bus.RF_WrData  <= rx;
          state          <= OP_B;
        end
        OP_B: if (vld) begin
          bus.RF_WrEn    <= 1'b1;
          bus.RF_Address <= ADDR_WIDTH'(1);
          bus.RF_WrData  <= rx;
          state          <= ALU_FUN_S;
        end
        ALU_FUN_S: if (vld) begin
          bus.ALU_FUN     <= rx[3:0];
          bus.ALU_EN      <= 1'b1;
          bus.CLK_GATE_EN <= 1'b1;
          state           <= ALU_WAIT;
        end
        ALU_WAIT: if (bus.ALU_OUT_Valid) begin
          alu_q           <= bus.ALU_OUT;
          bus.CLK_GATE_EN <= 1'b0;
          state           <= TX_LO;
        end
        TX_LO: if (!bus.FIFO_FULL) begin
          bus.TX_D_VLD  <= 1'b1;
          bus.TX_P_DATA <= alu_q[DATA_WIDTH-1:0];
          state         <= TX_HI;
        end
        TX_HI: if (!bus.FIFO_FULL) begin
          bus.TX_D_VLD  <= 1'b1;
          bus.TX_P_DATA <= alu_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed frames with a scoreboard of expected strobes checked by a monitor
module tb_sys_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  logic vld_s = 1'b0;
  logic full_s = 1'b0;
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_tx[$];
  logic [11:0] m_wr;
  logic [3:0]  m_rd;
  logic [3:0]  m_alu;
  logic [7:0]  m_tx;

  sys_ctrl_if bus();

  sys_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus.master));

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: got unexpected or missing event, expected none/one", name);
  endtask

  function automatic logic [28:0] outs();
    return {bus.RF_Address, bus.RF_WrEn, bus.RF_RdEn, bus.RF_WrData, bus.ALU_EN,
            bus.ALU_FUN, bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD};
  endfunction

  always @(posedge CLK) begin
    vld_s  <= bus.RX_D_VLD;
    full_s <= bus.FIFO_FULL;
  end

  // monitor: every strobe pops the oldest expectation of its kind
  always @(negedge CLK) if (RST) begin
    if (bus.RF_WrEn) begin
      if (exp_wr.size() == 0) fail("wr_unexpected");
      else begin
        m_wr = exp_wr.pop_front();
        check("wr", {19'd0, vld_s, bus.RF_Address, bus.RF_WrData}, {19'd0, 1'b1, m_wr});
      end
    end
    if (bus.RF_RdEn) begin
      if (exp_rd.size() == 0) fail("rd_unexpected");
      else begin
        m_rd = exp_rd.pop_front();
        check("rd", {27'd0, vld_s, bus.RF_Address}, {27'd0, 1'b1, m_rd});
      end
    end
    if (bus.ALU_EN) begin
      if (exp_alu.size() == 0) fail("alu_unexpected");
      else begin
        m_alu = exp_alu.pop_front();
        check("alu", {26'd0, vld_s, bus.ALU_FUN, bus.CLK_GATE_EN}, {26'd0, 1'b1, m_alu, 1'b1});
      end
    end
    if (bus.TX_D_VLD) begin
      if (exp_tx.size() == 0) fail("tx_unexpected");
      else begin
        m_tx = exp_tx.pop_front();
        check("tx", {23'd0, full_s, bus.TX_P_DATA}, {23'd0, 1'b0, m_tx});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(negedge CLK);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
  endtask

  task automatic wait_alu_en();
    int n = 0;
    while (!bus.ALU_EN && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n == 20) fail("alu_en_timeout");
  endtask

  task automatic alu_result(input logic [15:0] r);
    repeat (3) @(negedge CLK);
    bus.ALU_OUT = r;
    bus.ALU_OUT_Valid = 1'b1;
    @(negedge CLK);
    bus.ALU_OUT_Valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n == 100) fail("drain_timeout");
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int n;
    bus.RX_P_DATA = '0;
    bus.RX_D_VLD = 1'b0;
    bus.RF_RdData = '0;
    bus.RF_RdData_Valid = 1'b0;
    bus.ALU_OUT = '0;
    bus.ALU_OUT_Valid = 1'b0;
    bus.FIFO_FULL = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {3'd0, outs()}, 32'd0);
    RST = 1'b1;
    exp_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    drain();
    exp_rd.push_back(4'h5);
    exp_tx.push_back(8'h3C);
    send_byte(8'hBB); send_byte(8'h05);
    n = 0;
    while (!bus.RF_RdEn && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n == 20) fail("rd_en_timeout");
    repeat (2) @(negedge CLK);
    bus.RF_RdData = 8'h3C;
    bus.RF_RdData_Valid = 1'b1;
    @(negedge CLK);
    bus.RF_RdData_Valid = 1'b0;
    drain();
    exp_wr.push_back({4'h0, 8'h0A});
    exp_wr.push_back({4'h1, 8'h03});
    exp_alu.push_back(4'h2);
    exp_tx.push_back(8'h1E);
    exp_tx.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h02);
    wait_alu_en();
    check("gate_on", {31'd0, bus.CLK_GATE_EN}, 32'd1);
    alu_result(16'h001E);
    check("gate_off_next", {31'd0, bus.CLK_GATE_EN}, 32'd0);
    drain();
    check("gate_off_after", {31'd0, bus.CLK_GATE_EN}, 32'd0);
    exp_alu.push_back(4'h0);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    bus.FIFO_FULL = 1'b1;
    send_byte(8'hDD); send_byte(8'h00);
    wait_alu_en();
    alu_result(16'h1234);
    repeat (10) @(negedge CLK);
    check("bp_held", exp_tx.size(), 32'd2);
    bus.FIFO_FULL = 1'b0;
    drain();
    send_byte(8'h55);
    repeat (5) @(negedge CLK);
    check("illegal_idle", {3'd0, outs()}, {3'd0, 4'h1, 1'b0, 1'b0, 8'h03, 1'b0, 4'h0, 1'b0, 8'h12, 1'b0});
    exp_alu.push_back(4'h5);
    exp_tx.push_back(8'hBC);
    exp_tx.push_back(8'h0A);
    send_byte(8'hDD); send_byte(8'h05);
    wait_alu_en();
    send_byte(8'hAA); send_byte(8'hBB);
    alu_result(16'h0ABC);
    drain();
    exp_wr.push_back({4'h7, 8'h11});
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h11);
    drain();
    send_byte(8'hAA); send_byte(8'h02);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_mid_frame", {3'd0, outs()}, 32'd0);
    RST = 1'b1;
    send_byte(8'h7F);
    repeat (5) @(negedge CLK);
    check("after_reset_7f", {3'd0, outs()}, 32'd0);
    exp_wr.push_back({4'h3, 8'h44});
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h44);
    drain();
    check("queues_empty", exp_wr.size() + exp_rd.size() + exp_alu.size() + exp_tx.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command sequencer between the UART receiver and the system's register file, ALU and UART transmit FIFO. Consumes the parallel bytes from the UART receiver, one strobe per byte, and decodes them as a command frame. It then drives register-file writes and reads, ALU operations and clock gating, and pushes read data or ALU results into the TX FIFO. It is the only master of the register file and ALU in the final system.

## Interface
- Data_width, 8, width of RX/TX bytes and register-file data
- Addr_width, 4, register-file address width; address = received byte[Addr_width-1:0]
- CLK  input  1  system clock
- RST  input  1  asynchronous active-low reset
- RX_P_DATA  input  Data_width  received byte, valid while RX_D_VLD=1
- RX_D_VLD  input  1  one-cycle strobe per received byte, already synchronized to CLK
- RF_RdData  input  Data_width  register-file read data
- RF_RdData_Valid  input  1  one-cycle strobe qualifying RF_RdData
- ALU_OUT  input  2*Data_width  ALU result
- ALU_OUT_Valid  input  1  one-cycle strobe qualifying ALU_OUT
- FIFO_FULL  input  1  TX FIFO full; no push allowed while 1
- RF_Address  output  Addr_width  register-file address
- RF_WrEn  output  1  one-cycle write strobe
- RF_RdEn  output  1  one-cycle read strobe
- RF_WrData  output  Data_width  write data
- ALU_EN  output  1  one-cycle ALU start strobe
- ALU_FUN  output  4  ALU function code
- CLK_GATE_EN  output  1  ALU clock enable
- TX_P_DATA  output  Data_width  byte pushed to the TX FIFO
- TX_D_VLD  output  1  one-cycle FIFO push strobe

## Operation
- All outputs are registered. Every output resets to 0 and the state resets to IDLE asynchronously on RST=0, including mid-frame. Partial frames are discarded.
- Commands are decoded from the first byte in IDLE:
  - 0xAA: register write. Bytes: addr, data.
  - 0xBB: register read. Bytes: addr.
  - 0xCC: ALU with operands. Bytes: A, B, fun.
  - 0xDD: ALU without operands. Bytes: fun.
- Any other byte in IDLE is ignored; the block stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- WR_ADDR: on a byte, latch the address and go to WR_DATA.
- WR_DATA: on a byte, pulse RF_WrEn with RF_Address=latched address and RF_WrData=byte, then go to IDLE.
- RD_ADDR: on a byte, pulse RF_RdEn with RF_Address=byte and go to RD_WAIT.
- RD_WAIT: on RF_RdData_Valid, latch RF_RdData and go to TX_RD.
- TX_RD: while FIFO_FULL=0, pulse TX_D_VLD with TX_P_DATA=latched data and go to IDLE. While FIFO_FULL=1, hold with TX_D_VLD=0.
- OP_A: on a byte, pulse RF_WrEn to address 0 with data=byte and go to OP_B.
- OP_B: on a byte, pulse RF_WrEn to address 1 and go to ALU_FUN_S.
- ALU_FUN_S: on a byte, set ALU_FUN=byte[3:0], pulse ALU_EN, set CLK_GATE_EN=1, and go to ALU_WAIT.
- ALU_WAIT: on ALU_OUT_Valid, latch ALU_OUT, clear CLK_GATE_EN, and go to TX_LO.
- TX_LO: push ALU_OUT[7:0] when FIFO_FULL=0, then go to TX_HI.
- TX_HI: push ALU_OUT[15:8] when FIFO_FULL=0, then go to IDLE.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_RD, TX_LO and TX_HI is dropped. It does not start a new command.
- RF_Address, RF_WrData and ALU_FUN hold their last value between strobes.
- Strobe outputs are never high for more than one consecutive cycle.

## Timing
- Strobe timing: RF_WrEn, RF_RdEn and ALU_EN assert in the cycle after the CLK edge that samples the qualifying RX_D_VLD, which gives 1-cycle latency.
- CLK_GATE_EN asserts together with ALU_EN and deasserts the cycle after ALU_OUT_Valid is sampled.
- TX push timing: the first TX_D_VLD occurs no earlier than 1 cycle after the RF_RdData_Valid or ALU_OUT_Valid strobe that precedes it. In each push state, TX_D_VLD asserts one cycle after FIFO_FULL is sampled 0.
- TX_LO and TX_HI pushes are at least 1 cycle apart (back-to-back when FIFO_FULL=0).
- Back-to-back commands: a new command byte is accepted in the first IDLE cycle after a frame completes.

## Test plan
- Register write: after reset, send 0xAA, 0x05, 0x3C. Expect one RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C, then return to IDLE and no TX_D_VLD.
- Register read: send 0xBB, 0x05. Expect an RF_RdEn pulse with address 5. Return RF_RdData=0x3C with a valid strobe 2 cycles later. Expect one TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands: send 0xCC, 0x0A, 0x03, 0x02. Expect:
  - writes of 0x0A to address 0 and 0x03 to address 1;
  - ALU_EN with ALU_FUN=2 and CLK_GATE_EN=1.
  Return ALU_OUT=0x001E. Expect pushes 0x1E then 0x00, with CLK_GATE_EN low afterwards.
- FIFO backpressure: send 0xDD, 0x00 with FIFO_FULL=1 held for 10 cycles after ALU_OUT=0x1234 is valid. Expect no TX_D_VLD during those cycles. After release, expect 0x34 then 0x12.
- Illegal and dropped bytes: send 0x55 in IDLE and expect no outputs. Send bytes during ALU_WAIT and expect them to be ignored; the result transmits normally.
- Reset mid-frame: send 0xAA, 0x02, assert RST=0 for 2 cycles, release, then send 0x7F. Expect no RF_WrEn, all outputs 0, and the block still in IDLE.
